imem_fetch_ctrl: RTL and testbench
==================================

Name: imem_fetch_ctrl

Overview:
- Instruction-fetch sequencer for the CPU's 256-word combinational instruction ROM.
- Owns the program counter and drives the ROM address, read-enable and chip-enable.
- Captures fetched words into a small prefetch queue and presents them to decode with a valid/ready handshake.
- Accepts branch/jump redirects from execute and flushes stale prefetched words.

Parameters:
- ADDR_W, 8, ROM word-address width; PC width is ADDR_W+2 bits (byte address).
- DATA_W, 32, instruction word width.
- DEPTH, 2, prefetch queue entries (power of two, 2..8).
- RESET_PC, 0, byte address loaded into PC on reset; bits [1:0] must be 00.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- fetch_en  in  1  1 = fetch permitted; 0 = stop issuing ROM reads, hold state.
- redirect_valid  in  1  one-cycle pulse: load new PC, flush queue.
- redirect_pc  in  ADDR_W+2  redirect target byte address.
- rom_addr  out  ADDR_W  ROM word address, equals pc[ADDR_W+1:2].
- rom_read_en  out  1  ROM read enable.
- rom_ce  out  1  ROM chip enable.
- rom_data  in  DATA_W  ROM read data, valid combinationally in the same cycle as address/enables.
- inst_valid  out  1  queue head valid.
- inst_ready  in  1  decode accepts head this cycle.
- inst_data  out  DATA_W  head instruction word.
- inst_pc  out  ADDR_W+2  byte PC of head instruction.
- fetch_fault  out  1  sticky misaligned-redirect flag (see Optional Feature; otherwise tied 0).

Behaviour:
- Reset (rst_n=0, asynchronous): pc=RESET_PC, queue count=0, state=IDLE. All outputs 0 (inst_data=0, inst_pc=0, rom_addr=RESET_PC[ADDR_W+1:2]).
- FSM states: IDLE, FETCH, FAULT (FAULT exists only with the optional feature).
  - IDLE -> FETCH when fetch_en=1.
  - FETCH -> IDLE when fetch_en=0.
  - Redirect does not change state, except as described under Optional Feature.
- pop = inst_valid & inst_ready.
- issue = (state==FETCH) & ~redirect_valid & (count<DEPTH | pop).
- rom_ce = rom_read_en = issue. Both are 0 in every other cycle; rom_data is ignored when issue=0.
- On an issue cycle, at the clock edge:
  - rom_data and the current pc are written at the queue tail.
  - pc <= pc+4, wrapping modulo 2^(ADDR_W+2): byte address 0x3FC -> 0x000 for ADDR_W=8.
- Queue is FIFO, count 0..DEPTH.
  - Simultaneous issue and pop: count unchanged, head advances.
  - Pop on empty cannot occur, since inst_valid=0 when count=0.
- inst_valid = (count!=0). inst_data/inst_pc show the head entry and are registered, not combinational from rom_data.
- Fetch latency: first issue in the cycle after entering FETCH; its word is valid on inst_* after that edge (1 cycle ROM-to-decode).
- Steady state with inst_ready=1: one instruction per cycle.
- Full queue, no pop: no issue, pc holds, head stable. inst_data/inst_pc must not change while inst_valid=1 & inst_ready=0.
- Redirect (any state, priority over everything):
  - count <= 0 and pc <= {redirect_pc[ADDR_W+1:2],2'b00}.
  - Any pop in the same cycle is discarded; no issue in that cycle.
  - inst_valid is 0 the following cycle. The target instruction is valid 2 cycles after the redirect edge if state==FETCH.
- fetch_en dropping mid-stream: the queue keeps draining to decode and pc holds. Resuming fetch_en continues at the held pc.
- Reset asserted mid-operation: immediate return to reset values; queue contents lost.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined:
  - redirect_valid with redirect_pc[1:0]!=0 sets fetch_fault=1 (sticky until reset), flushes the queue, moves to FAULT and loads no PC.
  - FAULT issues no reads and ignores fetch_en and further redirects; only rst_n exits.
- Undefined: redirect_pc[1:0] are silently dropped, FAULT is absent, and fetch_fault is constant 0.

Test Plan:
- Reset release, fetch_en=1, inst_ready=1, ROM[k]=k+0x100 -> inst_pc 0x000,0x004,0x008… with inst_data 0x100,0x101,… on consecutive cycles; rom_ce high every FETCH cycle.
- inst_ready=0 for 5 cycles with DEPTH=2 -> exactly 2 issues, then rom_ce=0; inst_data/inst_pc held stable; on release, sequence resumes with no gap or duplicate.
- Redirect to 0x040 while 2 entries queued and inst_ready=1 -> popped word discarded; next valid inst_pc=0x040, data=ROM[16], two cycles after the redirect edge.
- Start at pc 0x3F8 -> fetches 0x3F8, 0x3FC, then wraps to 0x000 (rom_addr 254, 255, 0).
- fetch_en=0 mid-stream at pc 0x010 -> queue drains, rom_ce=0; re-enable -> next inst_pc=0x010 (or the next unfetched PC).
- FETCH_ALIGN_CHECK_EN defined, redirect_pc=0x042 -> fetch_fault=1, inst_valid=0, no further rom_ce until rst_n pulse. Undefined -> fetch proceeds from 0x040.

Source files
------------

// File: rtl/imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : imem_fetch_ctrl
// Purpose  : Instruction-fetch sequencer for a combinational instruction ROM.
//            Owns the program counter, issues one ROM read per cycle while
//            fetching, captures the returned words into a small prefetch
//            FIFO and hands them to decode over a valid/ready handshake.
//            Redirects from execute reload the PC and flush stale entries.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk            in   clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   fetch_en       in   1 = fetch permitted, 0 = stop issuing reads
//   redirect_valid in   one-cycle pulse: load redirect_pc, flush queue
//   redirect_pc    in   redirect target byte address (ADDR_W+2 bits)
//   rom_addr       out  ROM word address (pc[ADDR_W+1:2])
//   rom_read_en    out  ROM read enable (high on issue cycles only)
//   rom_ce         out  ROM chip enable (high on issue cycles only)
//   rom_data       in   ROM read data, combinational from rom_addr
//   inst_valid     out  queue head valid
//   inst_ready     in   decode accepts the head this cycle
//   inst_data      out  head instruction word
//   inst_pc        out  byte PC of the head instruction
//   fetch_fault    out  sticky misaligned-redirect flag
// ----------------------------------------------------------------------------
// Build option:
//   FETCH_ALIGN_CHECK_EN - when defined, a redirect to a non-word-aligned
//   target raises fetch_fault, flushes the queue and parks the sequencer in
//   FAULT until reset. When undefined the low target bits are dropped and
//   fetch_fault is tied low.
// ============================================================================
module imem_fetch_ctrl #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 2,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    input  logic              redirect_valid,
    input  logic [ADDR_W+1:0] redirect_pc,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_read_en,
    output logic              rom_ce,
    input  logic [DATA_W-1:0] rom_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W+1:0] inst_pc,
    output logic              fetch_fault
);

    localparam int c_pc_w  = ADDR_W + 2;
    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH + 1);

    localparam logic [c_pc_w-1:0]  c_reset_pc = c_pc_w'(RESET_PC);
    localparam logic [c_pc_w-1:0]  c_pc_step  = c_pc_w'(4);
    localparam logic [c_cnt_w-1:0] c_depth    = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_fetch = 2'd1;
`ifdef FETCH_ALIGN_CHECK_EN
    localparam logic [1:0] c_st_fault = 2'd2;
`endif

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_pc_w-1:0]  r_pc;
    logic [c_cnt_w-1:0] r_count;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [DATA_W-1:0]  r_q_data [DEPTH];
    logic [c_pc_w-1:0]  r_q_pc   [DEPTH];

    logic w_pop;
    logic w_issue;
    logic w_redirect;   // redirect that actually takes effect
    logic w_misaligned; // redirect that must raise the fault instead

`ifdef FETCH_ALIGN_CHECK_EN
    logic r_fault;
`else
    // Low target bits are intentionally discarded in this build.
    logic w_unused_align;
    assign w_unused_align = ^redirect_pc[1:0];
`endif

    // ------------------------------------------------------------------------
    // Handshake / issue decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_pop        = (r_count != '0) & inst_ready;
`ifdef FETCH_ALIGN_CHECK_EN
        // FAULT is terminal: later redirects are ignored altogether.
        w_redirect   = redirect_valid & (r_state != c_st_fault);
        w_misaligned = w_redirect & (redirect_pc[1:0] != 2'b00);
`else
        w_redirect   = redirect_valid;
        w_misaligned = 1'b0;
`endif
        // A slot freed by this cycle's pop can be refilled in the same cycle,
        // which is what sustains one instruction per cycle with DEPTH entries.
        w_issue      = (r_state == c_st_fetch) & ~redirect_valid &
                       ((r_count < c_depth) | w_pop);
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:  if (fetch_en)  w_state_nxt = c_st_fetch;
            c_st_fetch: if (!fetch_en) w_state_nxt = c_st_idle;
`ifdef FETCH_ALIGN_CHECK_EN
            c_st_fault: w_state_nxt = c_st_fault;
`endif
            default:    w_state_nxt = c_st_idle;
        endcase
`ifdef FETCH_ALIGN_CHECK_EN
        if (w_misaligned) begin
            w_state_nxt = c_st_fault;
        end
`endif
    end

    // ------------------------------------------------------------------------
    // State register, PC and prefetch queue
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_st_idle;
            r_pc     <= c_reset_pc;
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_q_data[i] <= '0;
                r_q_pc[i]   <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            if (w_redirect) begin
                // Flush: any pop this cycle is discarded along with the rest.
                r_count  <= '0;
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                if (!w_misaligned) begin
                    r_pc <= {redirect_pc[ADDR_W+1:2], 2'b00};
                end
            end else begin
                if (w_issue) begin
                    r_q_data[r_wr_ptr] <= rom_data;
                    r_q_pc[r_wr_ptr]   <= r_pc;
                    r_wr_ptr           <= r_wr_ptr + c_ptr_one;
                    r_pc               <= r_pc + c_pc_step;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_ptr_one;
                end
                case ({w_issue, w_pop})
                    2'b10:   r_count <= r_count + c_cnt_one;
                    2'b01:   r_count <= r_count - c_cnt_one;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fault <= 1'b0;
        end else if (w_misaligned) begin
            r_fault <= 1'b1;
        end
    end
    assign fetch_fault = r_fault;
`else
    assign fetch_fault = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign rom_addr    = r_pc[ADDR_W+1:2];
    assign rom_read_en = w_issue;
    assign rom_ce      = w_issue;
    assign inst_valid  = (r_count != '0);
    // Head comes from queue storage, so it stays stable under back-pressure.
    assign inst_data   = r_q_data[r_rd_ptr];
    assign inst_pc     = r_q_pc[r_rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_fetch_ctrl
// Purpose  : Scoreboard testbench for imem_fetch_ctrl. A reference model
//            tracks the PC, fetch state and the ordered list of words that
//            should be sitting in the prefetch queue; a separate monitor
//            compares the decode-side outputs against that list.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_fetch_ctrl;

    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 32;
    localparam int DEPTH    = 2;
    localparam int RESET_PC = 0;
`ifdef FETCH_ALIGN_CHECK_EN
    localparam bit ALIGN_CHECK = 1'b1;
`else
    localparam bit ALIGN_CHECK = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              fetch_en;
    logic              redirect_valid;
    logic [ADDR_W+1:0] redirect_pc;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_read_en;
    logic              rom_ce;
    logic [DATA_W-1:0] rom_data;
    logic              inst_valid;
    logic              inst_ready;
    logic [DATA_W-1:0] inst_data;
    logic [ADDR_W+1:0] inst_pc;
    logic              fetch_fault;

    always #5 clk = ~clk;

    imem_fetch_ctrl #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fetch_en      (fetch_en),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .rom_addr      (rom_addr),
        .rom_read_en   (rom_read_en),
        .rom_ce        (rom_ce),
        .rom_data      (rom_data),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst_data     (inst_data),
        .inst_pc       (inst_pc),
        .fetch_fault   (fetch_fault)
    );

    // ROM: low bits follow k+0x100, upper half randomised per word.
    logic [DATA_W-1:0] rom [256];
    assign rom_data = rom_ce ? rom[rom_addr] : 32'hBAD0_BAD0;

    // ------------------------------------------------------------------------
    // Scoreboard and counters
    // ------------------------------------------------------------------------
    typedef struct packed {
        logic [ADDR_W+1:0] pc;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t sb_q [$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model (state from the rules, queue contents as a list)
    // ------------------------------------------------------------------------
    typedef enum int {M_IDLE, M_FETCH, M_FAULT} mstate_t;
    mstate_t          m_state = M_IDLE;
    int               m_pc    = RESET_PC;
    bit               m_fault = 1'b0;

    // Model step runs just after the monitor so the list already reflects
    // this cycle's pop; "size after pop < DEPTH" equals "count<DEPTH or pop".
    always @(negedge clk) begin
        #1;
        if (!rst_n) begin
            sb_q.delete();
            m_pc    = RESET_PC;
            m_state = M_IDLE;
            m_fault = 1'b0;
        end else begin
            bit issue;
            issue = (m_state == M_FETCH) && !redirect_valid && (sb_q.size() < DEPTH);
            check("rom_ce", 64'(rom_ce), 64'(issue));
            check("rom_read_en", 64'(rom_read_en), 64'(issue));
            if (issue) check("rom_addr", 64'(rom_addr), 64'(m_pc / 4));
            if (redirect_valid && m_state != M_FAULT) begin
                sb_q.delete();
                if (ALIGN_CHECK && (redirect_pc % 4) != 0) begin
                    m_fault = 1'b1;
                    m_state = M_FAULT;
                end else begin
                    m_pc = int'(redirect_pc) - int'(redirect_pc % 4);
                end
            end else if (issue) begin
                exp_t e;
                e.pc   = (ADDR_W+2)'(m_pc);
                e.data = rom[m_pc / 4];
                sb_q.push_back(e);
                m_pc = (m_pc + 4) % 1024;
            end
            if (m_state == M_IDLE && fetch_en)        m_state = M_FETCH;
            else if (m_state == M_FETCH && !fetch_en) m_state = M_IDLE;
        end
    end

    // ------------------------------------------------------------------------
    // Monitor: decode-side outputs against the scoreboard
    // ------------------------------------------------------------------------
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_inst_valid", 64'(inst_valid), 64'd0);
            check("rst_inst_data", 64'(inst_data), 64'd0);
            check("rst_inst_pc", 64'(inst_pc), 64'd0);
            check("rst_rom_ce", 64'(rom_ce), 64'd0);
            check("rst_rom_addr", 64'(rom_addr), 64'(RESET_PC / 4));
            check("rst_fetch_fault", 64'(fetch_fault), 64'd0);
        end else begin
            check("inst_valid", 64'(inst_valid), 64'(sb_q.size() != 0));
            check("fetch_fault", 64'(fetch_fault), 64'(m_fault));
            if (sb_q.size() != 0) begin
                check("inst_pc", 64'(inst_pc), 64'(sb_q[0].pc));
                check("inst_data", 64'(inst_data), 64'(sb_q[0].data));
                if (inst_ready && !redirect_valid) void'(sb_q.pop_front());
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    task automatic drive(input bit fe, input bit rdy, input bit rv, input logic [ADDR_W+1:0] rpc);
        @(posedge clk);
        #1;
        fetch_en       = fe;
        inst_ready     = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n          = 1'b0;
        fetch_en       = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        for (int k = 0; k < 256; k++) begin
            rom[k] = ($urandom() & 32'hFFFF_0000) | (32'h100 + k);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Streaming from reset with decode always ready
        repeat (12) drive(1'b1, 1'b1, 1'b0, '0);
        // Back-pressure: queue fills, reads stop, head holds
        repeat (5) drive(1'b1, 1'b0, 1'b0, '0);
        repeat (6) drive(1'b1, 1'b1, 1'b0, '0);
        // Redirect with a full queue and a pop in the same cycle
        repeat (3) drive(1'b1, 1'b0, 1'b0, '0);
        drive(1'b1, 1'b1, 1'b1, 10'h040);
        repeat (6) drive(1'b1, 1'b1, 1'b0, '0);
        // PC wrap at the top of the ROM
        drive(1'b1, 1'b1, 1'b1, 10'h3F8);
        repeat (6) drive(1'b1, 1'b1, 1'b0, '0);
        // fetch_en dropped mid-stream, then resumed
        drive(1'b1, 1'b1, 1'b1, 10'h008);
        repeat (2) drive(1'b1, 1'b0, 1'b0, '0);
        repeat (4) drive(1'b0, 1'b1, 1'b0, '0);
        repeat (5) drive(1'b1, 1'b1, 1'b0, '0);
        // Asynchronous reset mid-operation
        reset_pulse();
        repeat (4) drive(1'b1, 1'b1, 1'b0, '0);
        // Misaligned redirect, then attempts to escape without reset
        drive(1'b1, 1'b1, 1'b1, 10'h042);
        repeat (4) drive(1'b1, 1'b1, 1'b0, '0);
        drive(1'b1, 1'b1, 1'b1, 10'h100);
        repeat (4) drive(1'b1, 1'b1, 1'b0, '0);
        reset_pulse();
        repeat (4) drive(1'b1, 1'b1, 1'b0, '0);

        // Randomised traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            logic [ADDR_W+1:0] rpc;
            rpc = (ADDR_W+2)'($urandom_range(0, 1023));
            if ($urandom_range(0, 7) != 0) rpc[1:0] = 2'b00;
            if (i % 500 == 499) begin
                reset_pulse();
            end else begin
                drive($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0,
                      $urandom_range(0, 15) == 0, rpc);
            end
        end
        repeat (4) drive(1'b0, 1'b1, 1'b0, '0);
        @(posedge clk);
        #2;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
